freq_meas: RTL and testbench
============================

Name: freq_meas

Overview:
- Receive-side counterpart to the clock divider: measures a divided clock (CLK_50/CLK_10/CLK_1 or any slow square wave) against the master clock CLK_in.
- Reports the period and high time in CLK_in cycles, a per-edge valid pulse, a lock flag for stable waveforms, and a stall flag when edges stop.
- Used as an on-chip self-check of the divider outputs and as a general edge-rate monitor.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- SYNC_STAGES, 2, synchroniser flops on SIG_in (minimum 2).
- TIMEOUT, 65535, cycles without a rising edge before STALL asserts; must be ≤ 2^CNT_W-1.

Ports:
- CLK_in  input  1  master clock; all logic on posedge.
- RST  input  1  reset.
- SIG_in  input  1  signal under measurement; asynchronous to CLK_in in general.
- PERIOD  output  CNT_W  last measured rise-to-rise period, in CLK_in cycles.
- HIGH_T  output  CNT_W  last measured rise-to-fall high time, in CLK_in cycles.
- MEAS_VALID  output  1  one-cycle pulse; PERIOD and HIGH_T hold a new, consistent pair.
- LOCKED  output  1  two consecutive identical (PERIOD, HIGH_T) pairs.
- STALL  output  1  no rising edge for TIMEOUT cycles.

Interface rule (already decided): one clock, CLK_in; RST is asynchronous and active-high.

Behaviour:
- Reset (RST=1, async):
  - PERIOD=0, HIGH_T=0, MEAS_VALID=0, LOCKED=0, STALL=0.
  - Synchroniser flops, previous-sample flop and counter cleared; state IDLE.
- Synchroniser:
  - SIG_in passes through SYNC_STAGES flops; s is the last stage, p is s delayed one cycle.
  - rise = s & ~p; fall = ~s & p.
  - Detection latency from a SIG_in transition is SYNC_STAGES+1 cycles; it is constant, so it cancels out of PERIOD and HIGH_T.
- Counter cnt:
  - On rise, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^CNT_W-1 (never wraps).
  - Consequence: in a rise cycle, cnt equals the cycles since the previous rise.
- States:
  - IDLE: wait for the first rise, then go to MEASURE. No measurement is output. Captured high time is discarded.
  - MEASURE:
    - On fall, latch h <= cnt (internal high-time register).
    - On rise, register PERIOD <= cnt and HIGH_T <= h; MEAS_VALID=1 in the following cycle for exactly one cycle.
    - If cnt reaches TIMEOUT with no rise, go to STALLED.
  - STALLED:
    - STALL=1 and LOCKED=0; PERIOD and HIGH_T hold their last values.
    - On the next rise, STALL<=0 and go to MEASURE. That rise is treated as a first edge: no MEAS_VALID.
- LOCKED:
  - Set on a measurement whose new (PERIOD, HIGH_T) equals the previous measurement.
  - Cleared on any mismatching measurement, on entry to STALLED, and on reset.
  - The first measurement after IDLE or STALLED never sets LOCKED.
- Boundary cases:
  - rise and fall cannot occur in the same cycle (they are mutually exclusive by construction).
  - A glitch narrower than one CLK_in cycle may be missed; this is not an error.
  - Period 2 (SIG_in toggling every cycle) must measure as PERIOD=2, HIGH_T=1.
  - If no fall occurs between two rises (impossible after synchronisation), HIGH_T repeats the old h.
  - TIMEOUT is compared on equality with cnt. Saturation guarantees the compare is reached.
- Reset mid-measurement:
  - Immediate return to the reset values.
  - If SIG_in is high when RST releases, the first s rise is a first edge only: no measurement.

Decomposition:
- Package freq_meas_pkg:
  - State enum {IDLE, MEASURE, STALLED}.
  - Default CNT_W.
  - Nominal divider constants P50=2, P10=10, P1=100 and their high times 1, 5, 50, for checkers.
- One sub-module, sync_edge_det (parameter SYNC_STAGES):
  - Ports: CLK_in, RST, SIG_in; outputs s, rise, fall.
  - Async active-high reset clears all flops.

Test Plan:
- SIG_in = divider CLK_50 (toggles every cycle) -> from the 2nd rise on, PERIOD=2, HIGH_T=1, MEAS_VALID every 2 cycles; LOCKED=1 after the 3rd rise.
- SIG_in = CLK_10 (5 high / 5 low) -> PERIOD=10, HIGH_T=5, MEAS_VALID every 10 cycles, LOCKED=1; CLK_1 case -> PERIOD=100, HIGH_T=50.
- Stable 10-cycle wave, then one period of 12 cycles (6/6) -> one MEAS_VALID with PERIOD=12, HIGH_T=6 and LOCKED drops to 0; it returns to 1 after two further matching 10/5 periods.
- TIMEOUT=50, SIG_in held low after locking -> STALL=1 exactly 50 cycles after the last rise, LOCKED=0, PERIOD held; next rise clears STALL with no MEAS_VALID, and the following rise produces a valid measurement.
- RST asserted mid-period (async, between clock edges) -> all outputs 0 immediately; after release with SIG_in high, no MEAS_VALID until two rises have been detected.
- Duty variation: 3 high / 7 low -> PERIOD=10, HIGH_T=3; a 1-cycle high pulse every 20 cycles -> PERIOD=20, HIGH_T=1.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared state type, default width and nominal divider constants
package freq_meas_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int P50 = 2;
  localparam int P10 = 10;
  localparam int P1 = 100;
  localparam int H50 = 1;
  localparam int H10 = 5;
  localparam int H1 = 50;
  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronises an async input and flags its rising/falling edges
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_in,
  input  logic RST,
  input  logic SIG_in,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic p_q;
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      p_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIG_in};
      p_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign s = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;
  assign fall = ~s & p_q;
endmodule

// File: rtl/freq_meas.sv
// freq_meas: measures period and high time of a slow signal in CLK_in cycles,
// with lock detection on repeated identical measurements and stall timeout
module freq_meas
  import freq_meas_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             SIG_in,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_T,
  output logic             MEAS_VALID,
  output logic             LOCKED,
  output logic             STALL
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, h_q, h_d, period_q, period_d, high_q, high_d;
  logic valid_q, valid_d, locked_q, locked_d, have_q, have_d;
  logic s, rise, fall, meas, to_hit, match;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK_in(CLK_in),
    .RST(RST),
    .SIG_in(SIG_in),
    .s(s),
    .rise(rise),
    .fall(fall)
  );
  assign meas = (state_q == MEASURE) && rise;
  assign to_hit = (state_q == MEASURE) && !rise && (cnt_q == CNT_W'(TIMEOUT));
  // have_q marks that a previous measurement exists to compare against
  assign match = have_q && (cnt_q == period_q) && (h_q == high_q);
  always_comb begin
    cnt_d = rise ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    state_d = rise ? MEASURE : (to_hit ? STALLED : state_q);
    h_d = ((state_q == MEASURE) && fall && !s) ? cnt_q : h_q;
    period_d = meas ? cnt_q : period_q;
    high_d = meas ? h_q : high_q;
    valid_d = meas;
    locked_d = meas ? match : (to_hit ? 1'b0 : locked_q);
    have_d = meas ? 1'b1 : (to_hit ? 1'b0 : have_q);
  end
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      h_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      locked_q <= 1'b0;
      have_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      h_q <= h_d;
      period_q <= period_d;
      high_q <= high_d;
      valid_q <= valid_d;
      locked_q <= locked_d;
      have_q <= have_d;
    end
  end
  assign PERIOD = period_q;
  assign HIGH_T = high_q;
  assign MEAS_VALID = valid_q;
  assign LOCKED = locked_q;
  assign STALL = (state_q == STALLED);
endmodule

// File: tb/tb_freq_meas.sv
// tb_freq_meas: table-driven waveforms with a scoreboard of expected measurements
module tb_freq_meas;
  import freq_meas_pkg::*;
  localparam int TO = 120;
  logic clk = 1'b0, rst = 1'b1, sig = 1'b0;
  logic [15:0] period, high_t;
  logic valid, locked, stall;
  freq_meas #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .CLK_in(clk),
    .RST(rst),
    .SIG_in(sig),
    .PERIOD(period),
    .HIGH_T(high_t),
    .MEAS_VALID(valid),
    .LOCKED(locked),
    .STALL(stall)
  );
  always #5 clk = ~clk;
  typedef struct {int p; int h;} exp_t;
  typedef struct {int hi; int lo; int n; logic lk;} vec_t;
  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[9];
  int errs = 0, checks = 0, cyc = 0, last_valid = -1;
  int prev_p = 0, prev_h = 0;
  bit have_prev = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // scoreboard: every MEAS_VALID must match the oldest expected pair
  always @(negedge clk) begin
    if (valid) begin
      last_valid = cyc;
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        mon_e = q.pop_front();
        check("period", int'(period), mon_e.p);
        check("high_t", int'(high_t), mon_e.h);
      end
    end
  end
  task automatic step(logic v);
    sig = v;
    @(posedge clk);
    #1;
  endtask
  // the rise starting this period completes the previous one
  task automatic drive_period(int hi, int lo);
    if (have_prev) q.push_back('{prev_p, prev_h});
    prev_p = hi + lo;
    prev_h = hi;
    have_prev = 1;
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask
  initial begin
    tbl[0] = '{H50, P50 - H50, 6, 1'b1};
    tbl[1] = '{H10, P10 - H10, 4, 1'b1};
    tbl[2] = '{H1, P1 - H1, 3, 1'b1};
    tbl[3] = '{3, 7, 4, 1'b1};
    tbl[4] = '{1, 19, 4, 1'b1};
    tbl[5] = '{5, 5, 4, 1'b1};
    tbl[6] = '{6, 6, 1, 1'b1};
    tbl[7] = '{5, 5, 1, 1'b0};
    tbl[8] = '{5, 5, 2, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", int'(period), 0);
    check("rst_high_t", int'(high_t), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_stall", int'(stall), 0);
    rst = 1'b0;
    repeat (3) step(1'b0);
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < tbl[i].n; k++) drive_period(tbl[i].hi, tbl[i].lo);
      check($sformatf("locked_rec%0d", i), int'(locked), int'(tbl[i].lk));
    end
    // stall: one more rise, then hold low until the timeout fires
    drive_period(5, 5);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (stall) break;
    end
    check("stall_seen", int'(stall), 1);
    check("stall_delay", cyc - last_valid, TO);
    check("stall_locked", int'(locked), 0);
    check("stall_period_held", int'(period), 10);
    check("stall_high_held", int'(high_t), 5);
    have_prev = 0;
    @(posedge clk);
    #1;
    drive_period(5, 5);
    check("stall_cleared", int'(stall), 0);
    drive_period(5, 5);
    drive_period(5, 5);
    check("relock_after_stall", int'(locked), 1);
    // async reset in the middle of a high phase
    q.push_back('{prev_p, prev_h});
    sig = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_period", int'(period), 0);
    check("async_high_t", int'(high_t), 0);
    check("async_valid", int'(valid), 0);
    check("async_locked", int'(locked), 0);
    check("async_stall", int'(stall), 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step(1'b1);
    repeat (5) step(1'b0);
    prev_p = 10;
    prev_h = 5;
    have_prev = 1;
    drive_period(5, 5);
    drive_period(5, 5);
    drive_period(5, 5);
    check("relock_after_reset", int'(locked), 1);
    repeat (30) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
